// File: rtl/reg_dump_uart.sv
// reg_dump_uart
//   Walks the register-file debug port through x0..x31 and streams every
//   word out as four 8N1 UART bytes, least-significant byte first.
//   Stream: x0[7:0], x0[15:8], ..., x31[31:24] (128 bytes, no header).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//
// Ports
//   clk                  in   system clock, rising edge
//   reset                in   asynchronous active-low reset
//   start                in   dump request, sampled only while idle
//   Debug_output[31:0]   in   register-file debug read data
//   PC[31:0]             in   program counter (used only with REG_DUMP_PC_EN)
//   Debug_Source_select  out  register index presented to the register file
//   tx                   out  UART serial line, idles high
//   busy                 out  high from the cycle after start acceptance
//                             until the done cycle has been left
//   done                 out  one-cycle pulse after the last stop bit
//
// Optional feature (macro REG_DUMP_PC_EN)
//   PC is captured when start is accepted and sent as a 33rd word after
//   x31, giving a 132-byte stream. Debug_Source_select holds 31 during
//   that extra slot.
module reg_dump_uart #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] Debug_output,
    input  logic [31:0] PC,
    output logic [4:0]  Debug_Source_select,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

`ifdef REG_DUMP_PC_EN
    localparam int IW = 6;
    localparam logic [IW-1:0] IDX_LAST = 6'd32;
`else
    localparam int IW = 5;
    localparam logic [IW-1:0] IDX_LAST = 5'd31;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [2:0]      r_bit;
    logic [1:0]      r_byte;
    logic [BW-1:0]   r_baud;
    logic [31:0]     r_buf;
    logic            r_tx;
    logic            r_busy;
    logic            r_done;
    logic [4:0]      r_sel;

    logic            w_baud_end;
    logic [2:0]      w_bit_next;
    logic [IW-1:0]   w_idx_next;
    logic [4:0]      w_sel_next;
    logic [31:0]     w_sel_word;

    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_bit_next = r_bit + 3'd1;
    assign w_idx_next = r_idx + 1'b1;

`ifdef REG_DUMP_PC_EN
    logic [31:0] r_pc;

    // The PC slot (index 32) keeps the register-file select parked on x31.
    assign w_sel_next = w_idx_next[5] ? 5'd31 : w_idx_next[4:0];
    assign w_sel_word = (r_idx == IDX_LAST) ? r_pc : Debug_output;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= '0;
        end else if (r_state == S_IDLE && start) begin
            r_pc <= PC;
        end
    end
`else
    logic w_pc_unused;

    assign w_pc_unused = ^PC;
    assign w_sel_next  = w_idx_next;
    assign w_sel_word  = Debug_output;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_baud  <= '0;
            r_buf   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sel   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_done <= 1'b0;
                    if (start) begin
                        r_idx   <= '0;
                        r_sel   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SEL;
                    end
                end
                // Debug_Source_select has been stable for this whole cycle,
                // so the combinational read data is sampled here only.
                S_SEL: begin
                    r_buf   <= w_sel_word;
                    r_byte  <= '0;
                    r_bit   <= '0;
                    r_baud  <= '0;
                    r_tx    <= 1'b0;
                    r_state <= S_START;
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_buf[{r_byte, 3'd0}];
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= w_bit_next;
                            r_tx  <= r_buf[{r_byte, w_bit_next}];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_byte != 2'd3) begin
                            r_byte  <= r_byte + 2'd1;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else if (r_idx != IDX_LAST) begin
                            // Explicit end compare: the index never wraps.
                            r_idx   <= w_idx_next;
                            r_sel   <= w_sel_next;
                            r_state <= S_SEL;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx                  = r_tx;
    assign busy                = r_busy;
    assign done                = r_done;
    assign Debug_Source_select = r_sel;

endmodule
